// File: rtl/chunked_serial_adder_pkg.sv
// Shared types and sizing helpers for the chunked serial adder.
package chunked_serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StHold
  } state_e;

  function automatic int unsigned total_w(input int unsigned chunk, input int unsigned nchunk);
    return chunk * nchunk;
  endfunction

  // Chunk index width; never zero so NCHUNK=1 still has a legal register.
  function automatic int unsigned idx_w(input int unsigned nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/chunked_serial_adder_chunk_add_slice.sv
// One CHUNK-bit generate/propagate adder slice; purely combinational.
module chunk_add_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // A scalar accumulator keeps c write-only here, avoiding a self-loop on the vector.
  always_comb begin
    logic carry;
    c     = '0;
    carry = cin;
    for (int j = 0; j < CHUNK; j++) begin
      c[j]  = carry;
      carry = g[j] | (p[j] & carry);
    end
    c[CHUNK] = carry;
  end

  assign sum      = p ^ c[CHUNK-1:0];
  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle TOTAL_W adder/subtractor, one CHUNK-bit slice per clock, LSB chunk first.
module chunked_serial_adder
  import chunked_serial_adder_pkg::*;
#(
  parameter int unsigned CHUNK   = 4,
  parameter int unsigned NCHUNK  = 4,
  localparam int unsigned TOTAL_W = total_w(CHUNK, NCHUNK)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [TOTAL_W-1:0] i_a,
  input  logic [TOTAL_W-1:0] i_b,
  input  logic               i_sub,
  input  logic               i_cin,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [TOTAL_W-1:0] o_sum,
  output logic               o_cout,
  output logic               o_ovf,
  output logic               o_busy
);

  localparam int unsigned IDX_W = idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NCHUNK - 1);

  state_e             state_q;
  logic [TOTAL_W-1:0] a_q;
  logic [TOTAL_W-1:0] b_q;
  logic [TOTAL_W-1:0] sum_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               cout_q;
  logic               ovf_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_c_msb_in;

  assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

  chunk_add_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a       (a_chunk),
    .b       (b_chunk),
    .cin     (carry_q),
    .sum     (slice_sum),
    .cout    (slice_cout),
    .c_msb_in(slice_c_msb_in)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            a_q     <= i_a;
            // Subtract as A + ~B + 1: invert B here, force the carry-in below.
            b_q     <= i_b ^ {TOTAL_W{i_sub}};
            carry_q <= i_sub | i_cin;
            sum_q   <= '0;
            idx_q   <= '0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          sum_q[idx_q*CHUNK +: CHUNK] <= slice_sum;
          carry_q                     <= slice_cout;
          if (idx_q == LastIdx) begin
            cout_q  <= slice_cout;
            ovf_q   <= slice_cout ^ slice_c_msb_in;
            state_q <= StHold;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StHold: begin
          if (i_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_ready = (state_q == StIdle);
  assign o_valid = (state_q == StHold);
  assign o_busy  = (state_q != StIdle);
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder with CHUNK=4, NCHUNK=4.
module tb_chunked_serial_adder;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic         i_sub = 1'b0;
  logic         i_cin = 1'b0;
  logic         o_valid;
  logic         i_ready = 1'b1;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_ovf;
  logic         o_busy;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  chunked_serial_adder #(
    .CHUNK (4),
    .NCHUNK(4)
  ) dut (
    .i_clk  (clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_a    (i_a),
    .i_b    (i_b),
    .i_sub  (i_sub),
    .i_cin  (i_cin),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_sum  (o_sum),
    .o_cout (o_cout),
    .o_ovf  (o_ovf),
    .o_busy (o_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a result is consumed on the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum 0x%0h with empty scoreboard", o_sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum", 32'(o_sum), 32'(e.sum));
        chk("cout", 32'(o_cout), 32'(e.cout));
        chk("ovf", 32'(o_ovf), 32'(e.ovf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 50) begin
      step();
      n++;
    end
    if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'd1);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input logic cin, input logic [W-1:0] es, input logic ec,
                      input logic eo, input bit push);
    exp_t e;
    wait_ready();
    if (push) begin
      e.sum  = es;
      e.cout = ec;
      e.ovf  = eo;
      exp_q.push_back(e);
    end
    i_a     = a;
    i_b     = b;
    i_sub   = sub;
    i_cin   = cin;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) step();
    i_rst = 1'b0;

    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_sum", 32'(o_sum), 32'd0);
    chk("rst_cout", 32'(o_cout), 32'd0);
    chk("rst_ovf", 32'(o_ovf), 32'd0);

    // Plain add with latency measurement; send returns in cycle 1.
    send(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b1);
    n = 1;
    while (!o_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency", 32'(n), 32'd5);

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    send(16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b1);

    // Backpressure, plus an i_valid pulse during CALC that must be ignored.
    wait_ready();
    i_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
    chk("calc_ready", 32'(o_ready), 32'd0);
    chk("calc_busy", 32'(o_busy), 32'd1);
    i_a     = 16'hAAAA;
    i_b     = 16'h5555;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 20) begin
      step();
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_sum", 32'(o_sum), 32'h3333);
      step();
    end
    i_ready = 1'b1;
    step();
    chk("valid_drop", 32'(o_valid), 32'd0);
    chk("ready_back", 32'(o_ready), 32'd1);

    // Reset in the second CALC cycle abandons the operation.
    send(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("midrst_ready", 32'(o_ready), 32'd1);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_sum", 32'(o_sum), 32'd0);
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    step();
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
